// File: rtl/timer_meter_pkg.sv
// Shared types and helpers for the 555 out-pin pulse meter.
package timer_meter_pkg;

    // Default width of the high/low cycle counters.
    localparam int unsigned CNT_W_DEF = 24;

    // Measurement FSM encoding.
    typedef logic [1:0] meas_state_t;
    localparam meas_state_t IDLE   = 2'd0;
    localparam meas_state_t MEAS_H = 2'd1;
    localparam meas_state_t MEAS_L = 2'd2;
    localparam meas_state_t STUCK  = 2'd3;

    // Increment that stops at max_val instead of wrapping.
    function automatic logic [31:0] sat_inc(input logic [31:0] val, input logic [31:0] max_val);
        return (val >= max_val) ? max_val : val + 32'd1;
    endfunction

endpackage

// File: rtl/pulse_sync_filt.sv
// Out-pin synchroniser with optional glitch filter (enabled by PULSE_METER_FILT_EN).
module pulse_sync_filt #(
    parameter int unsigned SYNC_STAGES = 2,
    parameter int unsigned FILT_LEN    = 4
) (
    input  logic i_clk,
    input  logic i_reset_n,
    input  logic i_pin,
    output logic o_level
);

    logic [SYNC_STAGES-1:0] r_sync;
    logic                   w_sync;

    // Shift the asynchronous pin through the synchroniser chain.
    always_ff @(posedge i_clk) begin
        if (!i_reset_n) begin
            r_sync <= '0;
        end else begin
            r_sync <= {r_sync[SYNC_STAGES-2:0], i_pin};
        end
    end

    assign w_sync = r_sync[SYNC_STAGES-1];

`ifdef PULSE_METER_FILT_EN
    localparam int unsigned FCNT_W = (FILT_LEN > 1) ? $clog2(FILT_LEN) : 1;

    logic              r_filt;
    logic [FCNT_W-1:0] r_fcnt;
    logic              w_flip;

    // Flip on the FILT_LEN-th consecutive differing sample; passing it through combinationally
    // keeps the added latency at FILT_LEN-1 for both edges.
    assign w_flip  = (w_sync != r_filt) && (r_fcnt == FCNT_W'(FILT_LEN - 1));
    assign o_level = w_flip ? w_sync : r_filt;

    // Count consecutive samples that disagree with the accepted level.
    always_ff @(posedge i_clk) begin
        if (!i_reset_n) begin
            r_filt <= 1'b0;
            r_fcnt <= '0;
        end else if (w_sync == r_filt) begin
            r_fcnt <= '0;
        end else if (w_flip) begin
            r_filt <= w_sync;
            r_fcnt <= '0;
        end else begin
            r_fcnt <= r_fcnt + 1'b1;
        end
    end
`else
    logic w_filt_unused;

    assign w_filt_unused = (FILT_LEN == 0);
    assign o_level       = w_sync;
`endif

endmodule

// File: rtl/timer_pulse_meter.sv
// Measures high time and period of the 555 out pin in clk cycles, reports each completed
// period over valid/ready and flags a static pin. Build macro: PULSE_METER_FILT_EN.
module timer_pulse_meter
    import timer_meter_pkg::*;
#(
    parameter int unsigned CNT_W       = CNT_W_DEF,
    parameter int unsigned SYNC_STAGES = 2,
    parameter int unsigned FILT_LEN    = 4
) (
    input  logic             i_clk,
    input  logic             i_reset_n,
    input  logic             i_en,
    input  logic             i_pulse_in,
    input  logic             i_meas_ready,
    output logic             o_meas_valid,
    output logic [CNT_W-1:0] o_meas_high,
    output logic [CNT_W:0]   o_meas_period,
    output logic             o_meas_overrun,
    output logic             o_stuck
);

    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    logic             w_s;
    logic             r_prev;
    logic             w_rise;
    logic             w_fall;
    meas_state_t      r_state;
    logic [CNT_W-1:0] r_hi_cnt;
    logic [CNT_W-1:0] r_lo_cnt;
    logic [CNT_W-1:0] w_hi_inc;
    logic [CNT_W-1:0] w_lo_inc;
    logic             r_stuck;
    logic             r_valid;
    logic [CNT_W-1:0] r_high;
    logic [CNT_W:0]   r_period;
    logic             r_overrun;
    logic             w_capture;
    logic             w_xfer;

    pulse_sync_filt #(
        .SYNC_STAGES (SYNC_STAGES),
        .FILT_LEN    (FILT_LEN)
    ) u_sync (
        .i_clk     (i_clk),
        .i_reset_n (i_reset_n),
        .i_pin     (i_pulse_in),
        .o_level   (w_s)
    );

    // Remember the previous clean level for edge detection.
    always_ff @(posedge i_clk) begin
        if (!i_reset_n) begin
            r_prev <= 1'b0;
        end else begin
            r_prev <= w_s;
        end
    end

    assign w_rise    = w_s & ~r_prev;
    assign w_fall    = ~w_s & r_prev;
    assign w_hi_inc  = CNT_W'(sat_inc(32'(r_hi_cnt), 32'(CNT_MAX)));
    assign w_lo_inc  = CNT_W'(sat_inc(32'(r_lo_cnt), 32'(CNT_MAX)));
    assign w_capture = i_en && (r_state == MEAS_L) && w_rise;
    assign w_xfer    = r_valid && i_meas_ready;

    // Measurement FSM: count high then low cycles, restart on every rise.
    always_ff @(posedge i_clk) begin
        if (!i_reset_n || !i_en) begin
            r_state  <= IDLE;
            r_hi_cnt <= '0;
            r_lo_cnt <= '0;
            r_stuck  <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_rise) begin
                        r_state  <= MEAS_H;
                        r_hi_cnt <= CNT_W'(1);
                        r_lo_cnt <= '0;
                    end
                end
                MEAS_H: begin
                    if (w_fall) begin
                        r_state  <= MEAS_L;
                        r_lo_cnt <= CNT_W'(1);
                    end else begin
                        r_hi_cnt <= w_hi_inc;
                        if (w_hi_inc == CNT_MAX) begin
                            r_state <= STUCK;
                            r_stuck <= 1'b1;
                        end
                    end
                end
                MEAS_L: begin
                    if (w_rise) begin
                        // Back-to-back: this rise is the first high cycle of the next period.
                        r_state  <= MEAS_H;
                        r_hi_cnt <= CNT_W'(1);
                        r_lo_cnt <= '0;
                    end else begin
                        r_lo_cnt <= w_lo_inc;
                        if (w_lo_inc == CNT_MAX) begin
                            r_state <= STUCK;
                            r_stuck <= 1'b1;
                        end
                    end
                end
                STUCK: begin
                    if (w_rise) begin
                        r_state  <= MEAS_H;
                        r_hi_cnt <= CNT_W'(1);
                        r_lo_cnt <= '0;
                        r_stuck  <= 1'b0;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    // Result register and handshake; a capture while a result is still pending is dropped.
    always_ff @(posedge i_clk) begin
        if (!i_reset_n) begin
            r_valid   <= 1'b0;
            r_high    <= '0;
            r_period  <= '0;
            r_overrun <= 1'b0;
        end else if (w_capture && (!r_valid || w_xfer)) begin
            r_valid   <= 1'b1;
            r_high    <= r_hi_cnt;
            r_period  <= {1'b0, r_hi_cnt} + {1'b0, r_lo_cnt};
            r_overrun <= 1'b0;
        end else if (w_capture) begin
            r_overrun <= 1'b1;
        end else if (w_xfer) begin
            r_valid   <= 1'b0;
            r_overrun <= 1'b0;
        end
    end

    assign o_meas_valid   = r_valid;
    assign o_meas_high    = r_high;
    assign o_meas_period  = r_period;
    assign o_meas_overrun = r_overrun;
    assign o_stuck        = r_stuck;

endmodule
